// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the out-of-order core back end.
//   ROB_IDX_W : width of a reorder-buffer tag (16-entry ROB by default)
//   A_REG_W   : width of an architectural register number
//   P_REG_W   : width of a physical register number
//   rob_entry_t : one reorder-buffer slot. valid/done track the life cycle,
//                 has_dest/rd/old_dest/new_dest carry the rename mapping so the
//                 previous physical register can be released at retirement.
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int A_REG_W   = 5;
    localparam int P_REG_W   = 6;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic               has_dest;
        logic [A_REG_W-1:0] rd;
        logic [P_REG_W-1:0] old_dest;
        logic [P_REG_W-1:0] new_dest;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order retirement buffer with two allocation slots and two
//   completion ports. Retired entries hand their old physical destination
//   back to the renamer.
//
//   Build option: define ROB_DUAL_RETIRE_EN to retire up to two entries per
//   cycle; without it at most one entry retires and free_reg1_* are tied 0.
//
//   Ports
//     clk_i, rst_n_i          : rising-edge clock, synchronous active-low reset
//     allocK_valid_i/...      : rename-stage allocation request, slot K=0,1
//     alloc_ready_o           : at least two entries free
//     allocK_idx_o            : tag given to slot K this cycle
//     completeK_valid_i/idx_i : execution-done report for a tag
//     free_regK_en_o/free_regK_o : old physical register released at retire
//     flush_i                 : discard every entry
//     rob_empty_o/rob_full_o/count_o : occupancy
//
//   Handshake: an allocation slot is accepted at the rising edge exactly when
//   allocK_valid_i && alloc_ready_o. alloc_ready_o never depends on the valid
//   inputs. Completion and flush are fire-and-forget with no backpressure.
// ----------------------------------------------------------------------------
module reorder_buffer
    import riscv_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_A_REGS  = 32,
    parameter int NUM_P_REGS  = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,

    input  logic                           alloc0_valid_i,
    input  logic                           alloc0_has_dest_i,
    input  logic [$clog2(NUM_A_REGS)-1:0]  alloc0_rd_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]  alloc0_old_dest_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]  alloc0_new_dest_i,
    input  logic                           alloc1_valid_i,
    input  logic                           alloc1_has_dest_i,
    input  logic [$clog2(NUM_A_REGS)-1:0]  alloc1_rd_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]  alloc1_old_dest_i,
    input  logic [$clog2(NUM_P_REGS)-1:0]  alloc1_new_dest_i,
    output logic                           alloc_ready_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] alloc0_idx_o,
    output logic [$clog2(NUM_ENTRIES)-1:0] alloc1_idx_o,

    input  logic                           complete0_valid_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0] complete0_idx_i,
    input  logic                           complete1_valid_i,
    input  logic [$clog2(NUM_ENTRIES)-1:0] complete1_idx_i,

    output logic                           free_reg0_en_o,
    output logic [$clog2(NUM_P_REGS)-1:0]  free_reg0_o,
    output logic                           free_reg1_en_o,
    output logic [$clog2(NUM_P_REGS)-1:0]  free_reg1_o,

    input  logic                           flush_i,
    output logic                           rob_empty_o,
    output logic                           rob_full_o,
    output logic [$clog2(NUM_ENTRIES):0]   count_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    rob_entry_t       entries [NUM_ENTRIES];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [PTR_W-1:0] count;
    logic             acc0;
    logic             acc1;
    logic             ret0;
    logic             ret1;
    logic             retire_ok;
    logic [1:0]       n_alloc;
    logic [1:0]       n_ret;
    rob_entry_t       new0;
    rob_entry_t       new1;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // The wrap bits make tail - head an exact occupancy from 0 to NUM_ENTRIES,
    // so no separate counter has to be kept in step with the pointers.
    assign count       = tail - head;
    assign count_o     = count;
    assign rob_empty_o = (count == '0);
    assign rob_full_o  = (count == PTR_W'(NUM_ENTRIES));

    // Readiness looks only at the current occupancy; a retirement in the same
    // cycle does not open up room early.
    assign alloc_ready_o = (count <= PTR_W'(NUM_ENTRIES - 2));
    assign alloc0_idx_o  = tail_idx;
    assign alloc1_idx_o  = tail_idx + IDX_W'(alloc0_valid_i);

    assign acc0 = alloc_ready_o & alloc0_valid_i;
    assign acc1 = alloc_ready_o & alloc1_valid_i;

    always_comb begin
        new0          = '0;
        new0.valid    = 1'b1;
        new0.has_dest = alloc0_has_dest_i;
        new0.rd       = alloc0_rd_i;
        new0.old_dest = alloc0_old_dest_i;
        new0.new_dest = alloc0_new_dest_i;
        new1          = '0;
        new1.valid    = 1'b1;
        new1.has_dest = alloc1_has_dest_i;
        new1.rd       = alloc1_rd_i;
        new1.old_dest = alloc1_old_dest_i;
        new1.new_dest = alloc1_new_dest_i;
    end

    // done is read from the registered array, so a completion landing this
    // cycle can only make its entry eligible from the next cycle on. Reset and
    // flush suppress retirement so no register is released for discarded work.
    assign retire_ok = rst_n_i & ~flush_i;
    assign ret0      = retire_ok & entries[head_idx].valid & entries[head_idx].done;

    assign free_reg0_en_o = ret0 & entries[head_idx].has_dest;
    assign free_reg0_o    = free_reg0_en_o ? entries[head_idx].old_dest : '0;

`ifdef ROB_DUAL_RETIRE_EN
    logic [IDX_W-1:0] head1_idx;

    assign head1_idx      = head_idx + IDX_W'(1);
    assign ret1           = ret0 & entries[head1_idx].valid & entries[head1_idx].done;
    assign free_reg1_en_o = ret1 & entries[head1_idx].has_dest;
    assign free_reg1_o    = free_reg1_en_o ? entries[head1_idx].old_dest : '0;
`else
    assign ret1           = 1'b0;
    assign free_reg1_en_o = 1'b0;
    assign free_reg1_o    = '0;
`endif

    assign n_alloc = {1'b0, acc0} + {1'b0, acc1};
    assign n_ret   = {1'b0, ret0} + {1'b0, ret1};

    // rd and new_dest ride along for commit-side visibility; nothing in this
    // block consumes them, so fold them into an intentionally unused signal.
    logic unused_payload;
    always_comb begin
        unused_payload = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            unused_payload = unused_payload ^ (^{entries[i].rd, entries[i].new_dest});
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Order matters: a retiring entry's clear overrides a completion
            // aimed at it. Allocations never target a live entry because
            // alloc_ready_o guarantees two free slots.
            if (complete0_valid_i && entries[complete0_idx_i].valid) begin
                entries[complete0_idx_i].done <= 1'b1;
            end
            if (complete1_valid_i && entries[complete1_idx_i].valid) begin
                entries[complete1_idx_i].done <= 1'b1;
            end
            if (ret0) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].done  <= 1'b0;
            end
`ifdef ROB_DUAL_RETIRE_EN
            if (ret1) begin
                entries[head1_idx].valid <= 1'b0;
                entries[head1_idx].done  <= 1'b0;
            end
`endif
            if (acc0) begin
                entries[alloc0_idx_o] <= new0;
            end
            if (acc1) begin
                entries[alloc1_idx_o] <= new1;
            end
            head <= head + PTR_W'(n_ret);
            tail <= tail + PTR_W'(n_alloc);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed scenarios followed by a randomized run. A queue-based reference
//   model of the in-flight instructions predicts every output each cycle, and
//   a scoreboard queue of expected freed registers checks retirement order.
//   Honours ROB_DUAL_RETIRE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int N   = 16;
    localparam int A_W = 5;
    localparam int P_W = 6;
    localparam int T_W = 4;

`ifdef ROB_DUAL_RETIRE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic           clk_i;
    logic           rst_n_i;
    logic           alloc0_valid_i;
    logic           alloc0_has_dest_i;
    logic [A_W-1:0] alloc0_rd_i;
    logic [P_W-1:0] alloc0_old_dest_i;
    logic [P_W-1:0] alloc0_new_dest_i;
    logic           alloc1_valid_i;
    logic           alloc1_has_dest_i;
    logic [A_W-1:0] alloc1_rd_i;
    logic [P_W-1:0] alloc1_old_dest_i;
    logic [P_W-1:0] alloc1_new_dest_i;
    logic           alloc_ready_o;
    logic [T_W-1:0] alloc0_idx_o;
    logic [T_W-1:0] alloc1_idx_o;
    logic           complete0_valid_i;
    logic [T_W-1:0] complete0_idx_i;
    logic           complete1_valid_i;
    logic [T_W-1:0] complete1_idx_i;
    logic           free_reg0_en_o;
    logic [P_W-1:0] free_reg0_o;
    logic           free_reg1_en_o;
    logic [P_W-1:0] free_reg1_o;
    logic           flush_i;
    logic           rob_empty_o;
    logic           rob_full_o;
    logic [T_W:0]   count_o;

    reorder_buffer #(.NUM_ENTRIES(N), .NUM_A_REGS(32), .NUM_P_REGS(64)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .alloc0_valid_i    (alloc0_valid_i),
        .alloc0_has_dest_i (alloc0_has_dest_i),
        .alloc0_rd_i       (alloc0_rd_i),
        .alloc0_old_dest_i (alloc0_old_dest_i),
        .alloc0_new_dest_i (alloc0_new_dest_i),
        .alloc1_valid_i    (alloc1_valid_i),
        .alloc1_has_dest_i (alloc1_has_dest_i),
        .alloc1_rd_i       (alloc1_rd_i),
        .alloc1_old_dest_i (alloc1_old_dest_i),
        .alloc1_new_dest_i (alloc1_new_dest_i),
        .alloc_ready_o     (alloc_ready_o),
        .alloc0_idx_o      (alloc0_idx_o),
        .alloc1_idx_o      (alloc1_idx_o),
        .complete0_valid_i (complete0_valid_i),
        .complete0_idx_i   (complete0_idx_i),
        .complete1_valid_i (complete1_valid_i),
        .complete1_idx_i   (complete1_idx_i),
        .free_reg0_en_o    (free_reg0_en_o),
        .free_reg0_o       (free_reg0_o),
        .free_reg1_en_o    (free_reg1_en_o),
        .free_reg1_o       (free_reg1_o),
        .flush_i           (flush_i),
        .rob_empty_o       (rob_empty_o),
        .rob_full_o        (rob_full_o),
        .count_o           (count_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int tag;
        bit has_dest;
        int old_dest;
        bit done;
    } ment_t;

    ment_t          mq[$];      // in-flight instructions, oldest first
    int             m_tail;     // next tag to hand out
    logic [P_W-1:0] exp_q[$];   // old_dest values expected to be freed, in order
    int             checks;
    int             errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ret0();
        return rst_n_i && !flush_i && mq.size() > 0 && mq[0].done;
    endfunction

    function automatic bit m_ret1();
        return DUAL && m_ret0() && mq.size() > 1 && mq[1].done;
    endfunction

    task automatic check_outputs();
        int c;
        bit r0;
        bit r1;
        bit f0;
        bit f1;
        c  = mq.size();
        r0 = m_ret0();
        r1 = m_ret1();
        f0 = r0 && mq[0].has_dest;
        f1 = r1 && mq[1].has_dest;
        chk("count", count_o, c);
        chk("alloc_ready", alloc_ready_o, c <= N - 2);
        chk("empty", rob_empty_o, c == 0);
        chk("full", rob_full_o, c == N);
        chk("idx0", alloc0_idx_o, m_tail % N);
        chk("idx1", alloc1_idx_o, (m_tail + int'(alloc0_valid_i)) % N);
        chk("free0_en", free_reg0_en_o, f0);
        chk("free0", free_reg0_o, f0 ? mq[0].old_dest : 0);
        chk("free1_en", free_reg1_en_o, f1);
        chk("free1", free_reg1_o, f1 ? mq[1].old_dest : 0);
        if (free_reg0_en_o === 1'b1) begin
            chk("sb_free0_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("sb_free0", free_reg0_o, exp_q.pop_front());
        end
        if (free_reg1_en_o === 1'b1) begin
            chk("sb_free1_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("sb_free1", free_reg1_o, exp_q.pop_front());
        end
    endtask

    task automatic mark_done(input int tag);
        foreach (mq[i]) if (mq[i].tag == tag) mq[i].done = 1'b1;
    endtask

    task automatic push_entry(input bit has, input int old);
        ment_t e;
        e.tag      = m_tail;
        e.has_dest = has;
        e.old_dest = old;
        e.done     = 1'b0;
        mq.push_back(e);
        if (has) exp_q.push_back(old[P_W-1:0]);
        m_tail = (m_tail + 1) % N;
    endtask

    // Advances the model across one rising edge using the held inputs.
    task automatic model_edge();
        bit r0;
        bit r1;
        bit rdy;
        r0  = m_ret0();
        r1  = m_ret1();
        rdy = mq.size() <= N - 2;
        if (!rst_n_i || flush_i) begin
            mq.delete();
            exp_q.delete();
            m_tail = 0;
            return;
        end
        if (r0) mq.delete(0);
        if (r1) mq.delete(0);
        if (complete0_valid_i) mark_done(int'(complete0_idx_i));
        if (complete1_valid_i) mark_done(int'(complete1_idx_i));
        if (rdy && alloc0_valid_i) push_entry(alloc0_has_dest_i, int'(alloc0_old_dest_i));
        if (rdy && alloc1_valid_i) push_entry(alloc1_has_dest_i, int'(alloc1_old_dest_i));
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 1
    // time unit later, well clear of the rising edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic step_nocheck();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        alloc0_valid_i    = 1'b0;
        alloc0_has_dest_i = 1'b0;
        alloc0_rd_i       = '0;
        alloc0_old_dest_i = '0;
        alloc0_new_dest_i = '0;
        alloc1_valid_i    = 1'b0;
        alloc1_has_dest_i = 1'b0;
        alloc1_rd_i       = '0;
        alloc1_old_dest_i = '0;
        alloc1_new_dest_i = '0;
        complete0_valid_i = 1'b0;
        complete0_idx_i   = '0;
        complete1_valid_i = 1'b0;
        complete1_idx_i   = '0;
        flush_i           = 1'b0;
    endtask

    task automatic drive_alloc0(input bit has, input int rd, input int old, input int nw);
        alloc0_valid_i    = 1'b1;
        alloc0_has_dest_i = has;
        alloc0_rd_i       = rd[A_W-1:0];
        alloc0_old_dest_i = old[P_W-1:0];
        alloc0_new_dest_i = nw[P_W-1:0];
    endtask

    task automatic drive_alloc1(input bit has, input int rd, input int old, input int nw);
        alloc1_valid_i    = 1'b1;
        alloc1_has_dest_i = has;
        alloc1_rd_i       = rd[A_W-1:0];
        alloc1_old_dest_i = old[P_W-1:0];
        alloc1_new_dest_i = nw[P_W-1:0];
    endtask

    task automatic drive_complete0(input int tag);
        complete0_valid_i = 1'b1;
        complete0_idx_i   = tag[T_W-1:0];
    endtask

    task automatic drive_complete1(input int tag);
        complete1_valid_i = 1'b1;
        complete1_idx_i   = tag[T_W-1:0];
    endtask

    task automatic dual_alloc_rand();
        drive_alloc0(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        drive_alloc1(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    endtask

    task automatic drain();
        for (int n = 0; n < 80 && mq.size() > 0; n++) begin
            idle();
            drive_complete0(mq[$urandom_range(0, mq.size() - 1)].tag);
            drive_complete1(mq[$urandom_range(0, mq.size() - 1)].tag);
            step();
        end
        idle();
        step();
        #1;
        chk("drain_empty", rob_empty_o, 1);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_count"}, count_o, 0);
        chk({pfx, "_ready"}, alloc_ready_o, 1);
        chk({pfx, "_empty"}, rob_empty_o, 1);
        chk({pfx, "_full"}, rob_full_o, 0);
        chk({pfx, "_idx0"}, alloc0_idx_o, 0);
        chk({pfx, "_free0_en"}, free_reg0_en_o, 0);
        chk({pfx, "_free0"}, free_reg0_o, 0);
        chk({pfx, "_free1_en"}, free_reg1_en_o, 0);
        chk({pfx, "_free1"}, free_reg1_o, 0);
    endtask

    // ---------------- stimulus ----------------
    int t;

    initial begin
        checks  = 0;
        errors  = 0;
        m_tail  = 0;
        rst_n_i = 1'b0;
        idle();
        step_nocheck();
        step_nocheck();
        rst_n_i = 1'b1;
        #1;
        check_reset_values("rst");
        step();

        // Dual allocation straight after reset
        drive_alloc0(1'b1, 1, 1, 32);
        drive_alloc1(1'b1, 2, 2, 33);
        #1;
        chk("dual_idx0", alloc0_idx_o, 0);
        chk("dual_idx1", alloc1_idx_o, 1);
        step();
        idle();
        #1;
        chk("dual_count", count_o, 2);

        // Out-of-order completion: tag 1 first, then tag 0
        drive_complete1(1);
        step();
        idle();
        drive_complete0(0);
        step();
        idle();
        #1;
        chk("ooo_free0_en", free_reg0_en_o, 1);
        chk("ooo_free0", free_reg0_o, 1);
        chk("ooo_free1_en", free_reg1_en_o, DUAL);
        chk("ooo_free1", free_reg1_o, DUAL ? 2 : 0);
        step();
        step();
        #1;
        chk("ooo_count", count_o, 0);

        // Fill to full from tag 0, then wrap
        flush_i = 1'b1;
        step();
        idle();
        for (int i = 0; i < 8; i++) begin
            dual_alloc_rand();
            step();
        end
        idle();
        #1;
        chk("full_flag", rob_full_o, 1);
        chk("full_ready", alloc_ready_o, 0);
        chk("full_count", count_o, 16);
        dual_alloc_rand();
        step();
        idle();
        drive_complete0(0);
        step();
        idle();
        step();
        #1;
        chk("c15_count", count_o, 15);
        chk("c15_ready", alloc_ready_o, 0);
        chk("c15_full", rob_full_o, 0);
        drive_complete0(1);
        step();
        idle();
        step();
        #1;
        chk("c14_ready", alloc_ready_o, 1);
        dual_alloc_rand();
        #1;
        chk("wrap_idx0", alloc0_idx_o, 0);
        chk("wrap_idx1", alloc1_idx_o, 1);
        step();
        idle();
        #1;
        chk("wrap_count", count_o, 16);
        drain();

        // has_dest=0 at head followed by a has_dest=1 entry
        t = m_tail;
        drive_alloc0(1'b0, 5, 7, 40);
        drive_alloc1(1'b1, 6, 9, 41);
        step();
        idle();
        drive_complete0(t);
        drive_complete1((t + 1) % N);
        step();
        idle();
        #1;
        chk("nodest_free0_en", free_reg0_en_o, 0);
        chk("nodest_free0", free_reg0_o, 0);
        chk("dest_free1_en", free_reg1_en_o, DUAL);
        chk("dest_free1", free_reg1_o, DUAL ? 9 : 0);
        step();
        #1;
        chk("dest_free0_en", free_reg0_en_o, !DUAL);
        chk("dest_free0", free_reg0_o, DUAL ? 0 : 9);
        step();

        // Flush with five in flight and a done head
        t = m_tail;
        dual_alloc_rand();
        step();
        dual_alloc_rand();
        step();
        idle();
        drive_alloc0(1'b1, 3, 11, 50);
        step();
        idle();
        drive_complete0(t);
        step();
        idle();
        flush_i = 1'b1;
        drive_complete0(t);
        drive_complete1((t + 1) % N);
        #1;
        chk("flush_free0_en", free_reg0_en_o, 0);
        chk("flush_free1_en", free_reg1_en_o, 0);
        step();
        idle();
        #1;
        chk("flush_count", count_o, 0);
        chk("flush_idx0", alloc0_idx_o, 0);

        // Mid-operation reset with three in flight
        dual_alloc_rand();
        step();
        idle();
        drive_alloc0(1'b1, 4, 12, 51);
        step();
        idle();
        drive_complete0(0);
        step();
        idle();
        rst_n_i = 1'b0;
        #1;
        chk("rst_mid_free0_en", free_reg0_en_o, 0);
        chk("rst_mid_free0", free_reg0_o, 0);
        step();
        #1;
        check_reset_values("rst_mid");
        rst_n_i = 1'b1;
        step();

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                drive_alloc0(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) != 0)
                drive_alloc1(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                drive_complete0(mq[$urandom_range(0, mq.size() - 1)].tag);
            if ($urandom_range(0, 2) == 0)
                drive_complete1(int'($urandom_range(0, N - 1)));
            if ($urandom_range(0, 63) == 0)
                flush_i = 1'b1;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
